// File: rtl/j4a_dec_pkg.sv
// ---------------------------------------------------------------------------
// j4a_dec_pkg
// Shared definitions for the J4A select decoder family.
//   mode_e  : operating mode encodings seen on the 'mode' input
//   state_e : sequencer state encoding used by sel_decoder_seq
//   PCNT_W  : width of the per-line pulse counter (PULSE_LEN up to 255)
// ---------------------------------------------------------------------------
package j4a_dec_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_STROBE = 2'b01,
        MODE_SCAN1  = 2'b10,
        MODE_SCANC  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STROBE = 2'b01,
        ST_SCAN   = 2'b10
    } state_e;

    localparam int PCNT_W = 8;

endpackage

// File: rtl/dec_onehot.sv
// ---------------------------------------------------------------------------
// dec_onehot
// Combinational index-to-one-hot decoder with output polarity selection.
// Ports:
//   sel   in  SEL_W      line index to assert
//   valid in  1          0 -> every line inactive
//   y     out 2**SEL_W   decoded lines, asserted level set by ACTIVE_LOW
// ---------------------------------------------------------------------------
module dec_onehot
    import j4a_dec_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  valid,
    output logic [(2**SEL_W)-1:0] y
);

    localparam int N_OUT = 2**SEL_W;

    logic [N_OUT-1:0] w_hot;

    always_comb begin
        w_hot = '0;
        if (valid) begin
            w_hot[sel] = 1'b1;
        end
        y = ACTIVE_LOW ? ~w_hot : w_hot;
    end

endmodule

// File: rtl/sel_decoder_seq.sv
// ---------------------------------------------------------------------------
// sel_decoder_seq
// Registered N-to-2^N select decoder with enable, selectable polarity and
// level / single-strobe / scan-once / scan-continuous modes.
// Ports:
//   clk   in  1          rising-edge clock
//   rst   in  1          synchronous reset, active-high (overrides en)
//   en    in  1          0 -> outputs inactive next cycle, operation aborted
//   mode  in  2          00 level, 01 strobe, 10 scan-once, 11 scan-continuous
//   sel   in  SEL_W      line index for level/strobe modes
//   req   in  1          start strobe/scan (only looked at while idle)
//   y     out 2**SEL_W   registered select lines, at most one asserted
//   busy  out 1          strobe/scan in progress
//   done  out 1          one-cycle completion pulse (never after an abort)
//   idx   out SEL_W      index of the asserted line, 0 when none
// ---------------------------------------------------------------------------
module sel_decoder_seq
    import j4a_dec_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int PULSE_LEN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  req,
    output logic [(2**SEL_W)-1:0] y,
    output logic                  busy,
    output logic                  done,
    output logic [SEL_W-1:0]      idx
);

    localparam int                N_OUT    = 2**SEL_W;
    localparam logic [SEL_W-1:0]  LAST_IDX = {SEL_W{1'b1}};
    localparam logic [PCNT_W-1:0] CNT_LOAD = PCNT_W'(PULSE_LEN - 1);
    localparam logic [N_OUT-1:0]  Y_IDLE   = ACTIVE_LOW ? {N_OUT{1'b1}} : {N_OUT{1'b0}};

    state_e              r_state;
    logic [PCNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]    r_idx;
    logic                r_cont;
    logic                r_busy;
    logic                r_done;
    logic [N_OUT-1:0]    r_y;

    state_e              w_state_nxt;
    logic [PCNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]    w_idx_nxt;
    logic                w_cont_nxt;
    logic                w_valid_nxt;
    logic                w_done_nxt;
    logic [N_OUT-1:0]    w_y_nxt;

    // Next-state logic. The line index and its valid flag are computed for the
    // coming cycle and decoded combinationally, so y is simply the registered
    // decode and can never show more than one asserted line.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_cont_nxt  = r_cont;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;

        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_cont_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    if (mode == MODE_LEVEL) begin
                        w_idx_nxt   = sel;
                        w_valid_nxt = 1'b1;
                    end else if (req) begin
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                        if (mode == MODE_STROBE) begin
                            w_state_nxt = ST_STROBE;
                            w_idx_nxt   = sel;
                        end else begin
                            w_state_nxt = ST_SCAN;
                            w_cont_nxt  = mode[0];
                        end
                    end
                end

                ST_STROBE: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end

                ST_SCAN: begin
                    w_valid_nxt = 1'b1;
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else if (r_idx != LAST_IDX) begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_cnt_nxt = CNT_LOAD;
                    end else if (r_cont && (mode == MODE_SCANC)) begin
                        // Wrap with no gap; continuing requires mode to still
                        // be scan-continuous at every wrap point.
                        w_idx_nxt  = '0;
                        w_cnt_nxt  = CNT_LOAD;
                        w_cont_nxt = mode[0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_cont_nxt  = 1'b0;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_cont_nxt  = 1'b0;
                end
            endcase
        end
    end

    dec_onehot #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .sel   (w_idx_nxt),
        .valid (w_valid_nxt),
        .y     (w_y_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_cont  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= Y_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_cont  <= w_cont_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
            r_y     <= w_y_nxt;
        end
    end

    assign y    = r_y;
    assign busy = r_busy;
    assign done = r_done;
    assign idx  = r_idx;

endmodule

// File: tb/tb_sel_decoder_seq.sv
// ---------------------------------------------------------------------------
// tb_sel_decoder_seq
// Five decoder builds share one stimulus stream:
//   d0 SEL_W=2 active-low  PULSE_LEN=3
//   d1 SEL_W=2 active-low  PULSE_LEN=2
//   d2 SEL_W=2 active-low  PULSE_LEN=1
//   d3 SEL_W=2 active-high PULSE_LEN=1
//   d4 SEL_W=3 active-high PULSE_LEN=4
// The reference model keeps, per build, the list of line indices still to be
// shown by the running operation (each line repeated PULSE_LEN times).
// ---------------------------------------------------------------------------
module tb_sel_decoder_seq;

    localparam int ND = 5;
    localparam int SW [ND] = '{2, 2, 2, 2, 3};
    localparam int AL [ND] = '{1, 1, 1, 0, 0};
    localparam int PL [ND] = '{3, 2, 1, 1, 4};
    localparam logic [3:0] LVL_AL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic       clk = 1'b0;
    logic       rst, en, req;
    logic [1:0] mode;
    logic [2:0] sel;

    logic [3:0] y0, y1, y2, y3;
    logic [7:0] y4;
    logic [1:0] idx0, idx1, idx2, idx3;
    logic [2:0] idx4;
    logic [ND-1:0] o_busy, o_done;
    logic [7:0] o_y   [ND];
    logic [2:0] o_idx [ND];

    int errors = 0;
    int checks = 0;

    int   plan   [ND][64];
    int   plan_n [ND];
    bit   m_cont [ND];
    logic [7:0] exp_y   [ND];
    logic [2:0] exp_idx [ND];
    logic [ND-1:0] exp_busy, exp_done;

    always #5 clk = ~clk;

    sel_decoder_seq #(.SEL_W(2), .ACTIVE_LOW(1'b1), .PULSE_LEN(3)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]), .req(req),
        .y(y0), .busy(o_busy[0]), .done(o_done[0]), .idx(idx0));
    sel_decoder_seq #(.SEL_W(2), .ACTIVE_LOW(1'b1), .PULSE_LEN(2)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]), .req(req),
        .y(y1), .busy(o_busy[1]), .done(o_done[1]), .idx(idx1));
    sel_decoder_seq #(.SEL_W(2), .ACTIVE_LOW(1'b1), .PULSE_LEN(1)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]), .req(req),
        .y(y2), .busy(o_busy[2]), .done(o_done[2]), .idx(idx2));
    sel_decoder_seq #(.SEL_W(2), .ACTIVE_LOW(1'b0), .PULSE_LEN(1)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]), .req(req),
        .y(y3), .busy(o_busy[3]), .done(o_done[3]), .idx(idx3));
    sel_decoder_seq #(.SEL_W(3), .ACTIVE_LOW(1'b0), .PULSE_LEN(4)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .req(req),
        .y(y4), .busy(o_busy[4]), .done(o_done[4]), .idx(idx4));

    assign o_y[0] = {4'b0, y0};
    assign o_y[1] = {4'b0, y1};
    assign o_y[2] = {4'b0, y2};
    assign o_y[3] = {4'b0, y3};
    assign o_y[4] = y4;
    assign o_idx[0] = {1'b0, idx0};
    assign o_idx[1] = {1'b0, idx1};
    assign o_idx[2] = {1'b0, idx2};
    assign o_idx[3] = {1'b0, idx3};
    assign o_idx[4] = idx4;

    // ---------------- reference model ----------------
    function automatic void show(int d, int line, bit b, bit dn);
        logic [7:0] hot, mask;
        mask = 8'((1 << (1 << SW[d])) - 1);
        hot  = (line >= 0) ? 8'(1 << line) : 8'h00;
        exp_y[d]    = (AL[d] != 0) ? (~hot & mask) : hot;
        exp_idx[d]  = (line >= 0) ? 3'(line) : 3'd0;
        exp_busy[d] = b;
        exp_done[d] = dn;
    endfunction

    function automatic void push(int d, int v);
        plan[d][plan_n[d]] = v;
        plan_n[d]++;
    endfunction

    function automatic void fill_sweep(int d);
        for (int k = 0; k < (1 << SW[d]); k++)
            for (int r = 0; r < PL[d]; r++) push(d, k);
    endfunction

    // Predict outputs after the coming edge from the inputs currently applied.
    function automatic void model_edge();
        for (int d = 0; d < ND; d++) begin
            int n;
            n = 1 << SW[d];
            if (rst || !en) begin
                plan_n[d] = 0;
                show(d, -1, 0, 0);
            end else if (plan_n[d] > 0) begin
                for (int i = 0; i < plan_n[d] - 1; i++) plan[d][i] = plan[d][i+1];
                plan_n[d]--;
                if (plan_n[d] == 0 && m_cont[d] && mode == 2'd3) fill_sweep(d);
                if (plan_n[d] == 0) show(d, -1, 0, 1);
                else                show(d, plan[d][0], 1, 0);
            end else if (mode == 2'd0) begin
                show(d, int'(sel) & (n - 1), 0, 0);
            end else if (req) begin
                if (mode == 2'd1) begin
                    for (int r = 0; r < PL[d]; r++) push(d, int'(sel) & (n - 1));
                    m_cont[d] = 1'b0;
                end else begin
                    fill_sweep(d);
                    m_cont[d] = (mode == 2'd3);
                end
                show(d, plan[d][0], 1, 0);
            end else begin
                show(d, -1, 0, 0);
            end
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 2'd0; sel = 3'd0; req = 1'b0;
        step();
        checks++;
        if ({y0, o_busy[0], o_done[0], idx0} !== {4'b1111, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_d0: y=%b busy=%b done=%b idx=%0d, want y=1111 busy=0 done=0 idx=0",
                     y0, o_busy[0], o_done[0], idx0);
        end
        rst = 1'b0; en = 1'b1; mode = 2'd0; sel = 3'd2;
        step();
        checks++;
        if ({y0, idx0, y3} !== {4'b1011, 2'd2, 4'b0100}) begin
            errors++;
            $display("FAIL reset_level: y0=%b idx0=%0d y3=%b, want 1011 2 0100", y0, idx0, y3);
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({o_y[d], o_busy[d], o_done[d], o_idx[d]} !== {exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]}) begin
                errors++;
                $display("FAIL reset d%0d: y=%b busy=%b done=%b idx=%0d, want y=%b busy=%b done=%b idx=%0d",
                         d, o_y[d], o_busy[d], o_done[d], o_idx[d], exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]);
            end
        end
    endtask

    task automatic test_level();
        mode = 2'd0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            if (s < 4) begin
                checks++;
                if (y0 !== LVL_AL[s] || y3 !== 4'(1 << s)) begin
                    errors++;
                    $display("FAIL level_sel%0d: y0=%b y3=%b, want %b %b", s, y0, y3, LVL_AL[s], 4'(1 << s));
                end
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({o_y[d], o_busy[d], o_done[d], o_idx[d]} !== {exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]}) begin
                    errors++;
                    $display("FAIL level d%0d sel%0d: y=%b busy=%b done=%b idx=%0d, want y=%b busy=%b done=%b idx=%0d",
                             d, s, o_y[d], o_busy[d], o_done[d], o_idx[d], exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]);
                end
            end
        end
    endtask

    task automatic test_strobe();
        mode = 2'd1; sel = 3'd1; req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            // second request during busy, with a different mode, must be ignored
            req  = (i == 1);
            mode = (i == 1) ? 2'd2 : 2'd1;
            checks++;
            if ((i <= 3 && (y0 !== 4'b1101 || o_busy[0] !== 1'b1 || o_done[0] !== 1'b0)) ||
                (i == 4 && (y0 !== 4'b1111 || o_busy[0] !== 1'b0 || o_done[0] !== 1'b1)) ||
                (i >  4 && (y0 !== 4'b1111 || o_busy[0] !== 1'b0 || o_done[0] !== 1'b0))) begin
                errors++;
                $display("FAIL strobe_d0 cyc%0d: y=%b busy=%b done=%b", i, y0, o_busy[0], o_done[0]);
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({o_y[d], o_busy[d], o_done[d], o_idx[d]} !== {exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]}) begin
                    errors++;
                    $display("FAIL strobe d%0d cyc%0d: y=%b busy=%b done=%b idx=%0d, want y=%b busy=%b done=%b idx=%0d",
                             d, i, o_y[d], o_busy[d], o_done[d], o_idx[d], exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]);
                end
            end
        end
        req = 1'b0;
    endtask

    task automatic test_scan_once();
        mode = 2'd2; req = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            step();
            req = 1'b0;
            if (i <= 8) begin
                checks++;
                if (y1 !== LVL_AL[(i-1)/2] || idx1 !== 2'((i-1)/2) || o_busy[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL scan1_d1 cyc%0d: y=%b idx=%0d busy=%b, want %b %0d 1",
                             i, y1, idx1, o_busy[1], LVL_AL[(i-1)/2], (i-1)/2);
                end
            end else if (i == 9) begin
                checks++;
                if ({y1, o_busy[1], o_done[1]} !== {4'b1111, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL scan1_done_d1: y=%b busy=%b done=%b, want 1111 0 1", y1, o_busy[1], o_done[1]);
                end
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({o_y[d], o_busy[d], o_done[d], o_idx[d]} !== {exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]}) begin
                    errors++;
                    $display("FAIL scan1 d%0d cyc%0d: y=%b busy=%b done=%b idx=%0d, want y=%b busy=%b done=%b idx=%0d",
                             d, i, o_y[d], o_busy[d], o_done[d], o_idx[d], exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]);
                end
            end
        end
    endtask

    task automatic test_scan_cont();
        mode = 2'd3; req = 1'b1; sel = 3'd0;
        for (int i = 1; i <= 45; i++) begin
            step();
            req = 1'b0;
            if (i == 6) mode = 2'd0;
            if (i <= 8) begin
                checks++;
                if (y2 !== LVL_AL[(i-1)%4] || o_busy[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL scanc_d2 cyc%0d: y=%b busy=%b, want %b 1", i, y2, o_busy[2], LVL_AL[(i-1)%4]);
                end
            end else if (i == 9) begin
                checks++;
                if ({y2, o_busy[2], o_done[2]} !== {4'b1111, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL scanc_done_d2: y=%b busy=%b done=%b, want 1111 0 1", y2, o_busy[2], o_done[2]);
                end
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({o_y[d], o_busy[d], o_done[d], o_idx[d]} !== {exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]}) begin
                    errors++;
                    $display("FAIL scanc d%0d cyc%0d: y=%b busy=%b done=%b idx=%0d, want y=%b busy=%b done=%b idx=%0d",
                             d, i, o_y[d], o_busy[d], o_done[d], o_idx[d], exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]);
                end
            end
        end
    endtask

    task automatic test_abort();
        // i: 1 strobe start, 3 en drop, 5 scan start, 7 reset
        for (int i = 1; i <= 9; i++) begin
            en   = (i != 3);
            rst  = (i == 7);
            req  = (i == 1) || (i == 5);
            mode = (i < 5) ? 2'd1 : 2'd2;
            sel  = 3'd2;
            step();
            if (i == 3 || i == 4 || i == 7 || i == 8) begin
                checks++;
                if ({y0, o_busy[0], o_done[0], idx0} !== {4'b1111, 1'b0, 1'b0, 2'd0}) begin
                    errors++;
                    $display("FAIL abort_d0 cyc%0d: y=%b busy=%b done=%b idx=%0d, want 1111 0 0 0",
                             i, y0, o_busy[0], o_done[0], idx0);
                end
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({o_y[d], o_busy[d], o_done[d], o_idx[d]} !== {exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]}) begin
                    errors++;
                    $display("FAIL abort d%0d cyc%0d: y=%b busy=%b done=%b idx=%0d, want y=%b busy=%b done=%b idx=%0d",
                             d, i, o_y[d], o_busy[d], o_done[d], o_idx[d], exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]);
                end
            end
        end
        rst = 1'b0; en = 1'b1; req = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            en  = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            sel = 3'($urandom_range(0, 7));
            req = ($urandom_range(0, 2) == 0);
            step();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({o_y[d], o_busy[d], o_done[d], o_idx[d]} !== {exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]}) begin
                    errors++;
                    $display("FAIL random d%0d cyc%0d: y=%b busy=%b done=%b idx=%0d, want y=%b busy=%b done=%b idx=%0d",
                             d, i, o_y[d], o_busy[d], o_done[d], o_idx[d], exp_y[d], exp_busy[d], exp_done[d], exp_idx[d]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            plan_n[d] = 0;
            m_cont[d] = 1'b0;
        end
        rst = 1'b1; en = 1'b0; mode = 2'd0; sel = 3'd0; req = 1'b0;
        #2;
        test_reset();
        test_level();
        test_strobe();
        test_scan_once();
        test_scan_cont();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
